// File: rtl/dcf77_sync_ctrl_pkg.sv
// Shared types, DCF77 field positions and BCD helpers for the DCF77 sync controller.
// Contents:
//   sync_state_t  - controller state (idle / acquire / locked / holdover)
//   fail_t        - failure diagnostic codes shown on fail_code
//   *Lsb/*Msb     - bit positions of the DCF77 time and date fields
//   bcd_inc_mod60 - BCD minute increment that wraps 59 -> 00
package dcf77_sync_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAcquire,
      StLocked,
      StHoldover
   } sync_state_t;

   typedef enum logic [2:0] {
      FailNone    = 3'd0,
      FailRxErr   = 3'd1,
      FailMarker  = 3'd2,
      FailParity  = 3'd3,
      FailRange   = 3'd4,
      FailIncons  = 3'd5,
      FailTimeout = 3'd6
   } fail_t;

   // Bit n of the frame is second n of the minute.
   localparam int unsigned MinuteMarkBit = 0;
   localparam int unsigned StartBit      = 20;
   localparam int unsigned MinLsb        = 21;
   localparam int unsigned MinMsb        = 27;
   localparam int unsigned ParMinBit     = 28;
   localparam int unsigned HourLsb       = 29;
   localparam int unsigned HourMsb       = 34;
   localparam int unsigned ParHourBit    = 35;
   localparam int unsigned DayLsb        = 36;
   localparam int unsigned DayMsb        = 41;
   localparam int unsigned DowLsb        = 42;
   localparam int unsigned DowMsb        = 44;
   localparam int unsigned MonLsb        = 45;
   localparam int unsigned MonMsb        = 49;
   localparam int unsigned YearLsb       = 50;
   localparam int unsigned YearMsb       = 57;
   localparam int unsigned ParDateBit    = 58;

   // Two-digit BCD minute plus one, wrapping 59 to 00.
   function automatic logic [6:0] bcd_inc_mod60(input logic [6:0] m);
      logic [6:0] r;
      if (m == 7'h59) begin
         r = 7'h00;
      end else if (m[3:0] >= 4'd9) begin
         r = {m[6:4] + 3'd1, 4'd0};
      end else begin
         r = {m[6:4], m[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/dcf77_sync_ctrl_frame_check.sv
// Combinational qualification of one decoded DCF77 minute frame.
// Checks run in priority order; the first failing one is reported.
// Ports:
//   frame_error_i - receiver error flag for this frame
//   frame_data_i  - DCF77 bits [58:0]
//   fail_o        - FailNone, FailRxErr, FailMarker, FailParity or FailRange
module dcf77_frame_check
   import dcf77_sync_ctrl_pkg::*;
(
   input  logic        frame_error_i,
   input  logic [58:0] frame_data_i,
   output fail_t       fail_o
);

   logic [6:0] min_f;
   logic [5:0] hour_f;
   logic [5:0] day_f;
   logic [2:0] dow_f;
   logic [4:0] mon_f;
   logic [7:0] year_f;
   logic       marker_bad;
   logic       parity_bad;
   logic       range_bad;
   logic       unused_bits;

   assign min_f  = frame_data_i[MinMsb:MinLsb];
   assign hour_f = frame_data_i[HourMsb:HourLsb];
   assign day_f  = frame_data_i[DayMsb:DayLsb];
   assign dow_f  = frame_data_i[DowMsb:DowLsb];
   assign mon_f  = frame_data_i[MonMsb:MonLsb];
   assign year_f = frame_data_i[YearMsb:YearLsb];

   // Weather/call/DST bits play no part in qualification.
   assign unused_bits = ^frame_data_i[StartBit-1:MinuteMarkBit+1];

   assign marker_bad = frame_data_i[MinuteMarkBit] | ~frame_data_i[StartBit];

   // Even parity: each group including its parity bit must XOR to zero.
   assign parity_bad = (^frame_data_i[ParMinBit:MinLsb])
                     | (^frame_data_i[ParHourBit:HourLsb])
                     | (^frame_data_i[ParDateBit:DayLsb]);

   always_comb begin
      range_bad = 1'b0;
      if (min_f[3:0] > 4'd9 || min_f[6:4] > 3'd5) range_bad = 1'b1;
      if (hour_f[3:0] > 4'd9 || hour_f[5:4] > 2'd2) range_bad = 1'b1;
      if (hour_f[5:4] == 2'd2 && hour_f[3:0] > 4'd3) range_bad = 1'b1;
      if (day_f[3:0] > 4'd9 || day_f == 6'h00) range_bad = 1'b1;
      if (day_f[5:4] == 2'd3 && day_f[3:0] > 4'd1) range_bad = 1'b1;
      if (dow_f == 3'd0) range_bad = 1'b1;
      if (mon_f[3:0] > 4'd9 || mon_f == 5'h00) range_bad = 1'b1;
      if (mon_f[4] && mon_f[3:0] > 4'd2) range_bad = 1'b1;
      if (year_f[3:0] > 4'd9 || year_f[7:4] > 4'd9) range_bad = 1'b1;
   end

   always_comb begin
      fail_o = FailNone;
      if (frame_error_i) begin
         fail_o = FailRxErr;
      end else if (marker_bad) begin
         fail_o = FailMarker;
      end else if (parity_bad) begin
         fail_o = FailParity;
      end else if (range_bad) begin
         fail_o = FailRange;
      end
   end

endmodule

// File: rtl/dcf77_sync_ctrl.sv
// DCF77 sync controller: qualifies decoded minute frames and decides when the
// time-of-day clock is loaded (acquire / locked / holdover state machine).
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   clk_en         - 10 ms tick
//   enable         - 0 forces idle, no loads
//   frame_strobe   - new frame on frame_data / frame_error this cycle
//   load           - one-cycle pulse, cycle after an accepted strobe
//   locked         - high in LOCKED
//   holdover       - high in HOLDOVER
//   fail_code      - last failure code (fail_t)
//   bad_frame_cnt  - saturating count of rejected frames
module dcf77_sync_ctrl
   import dcf77_sync_ctrl_pkg::*;
#(
   parameter int unsigned CONFIRM_FRAMES = 2,
   parameter int unsigned TIMEOUT_TICKS  = 12000,
   parameter int unsigned HOLDOVER_TICKS = 360000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        enable,
   input  logic        frame_strobe,
   input  logic        frame_error,
   input  logic [58:0] frame_data,
   output logic        load,
   output logic        locked,
   output logic        holdover,
   output logic [2:0]  fail_code,
   output logic [7:0]  bad_frame_cnt
);

   localparam int unsigned TmoW  = $clog2(TIMEOUT_TICKS + 1);
   localparam int unsigned HoldW = $clog2(HOLDOVER_TICKS + 1);
   localparam logic [TmoW-1:0]  TmoLast    = TmoW'(TIMEOUT_TICKS - 1);
   localparam logic [HoldW-1:0] HoldLast   = HoldW'(HOLDOVER_TICKS - 1);
   localparam logic [2:0]       ConfirmCnt = 3'(CONFIRM_FRAMES);

   sync_state_t      state_q, state_d;
   logic [2:0]       consec_q, consec_d;
   logic             ref_valid_q, ref_valid_d;
   logic [6:0]       ref_min_q, ref_min_d;
   logic [5:0]       ref_hour_q, ref_hour_d;
   logic [21:0]      ref_date_q, ref_date_d;
   logic [TmoW-1:0]  tmo_q, tmo_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [2:0]       fail_q, fail_d;
   logic [7:0]       bad_q, bad_d;
   logic             load_q, load_d;

   fail_t      chk;
   logic [6:0] new_min;
   logic       consistent;
   logic       incons;
   logic       timeout;
   logic [2:0] consec_inc;
   logic [2:0] consec_new;
   logic [7:0] bad_inc;

   dcf77_frame_check u_frame_check (
      .frame_error_i (frame_error),
      .frame_data_i  (frame_data),
      .fail_o        (chk)
   );

   assign new_min = frame_data[MinMsb:MinLsb];

   // At the top of the hour the date may roll over, so only the minute is compared.
   assign consistent = (new_min == bcd_inc_mod60(ref_min_q))
                     && ((new_min == 7'h00)
                         || (frame_data[HourMsb:HourLsb] == ref_hour_q
                             && frame_data[YearMsb:DayLsb] == ref_date_q));
   assign incons     = ref_valid_q && !consistent;
   assign consec_inc = (consec_q == 3'd7) ? 3'd7 : consec_q + 3'd1;
   assign bad_inc    = (bad_q == 8'hff) ? 8'hff : bad_q + 8'd1;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         consec_q    <= '0;
         ref_valid_q <= 1'b0;
         ref_min_q   <= '0;
         ref_hour_q  <= '0;
         ref_date_q  <= '0;
         tmo_q       <= '0;
         hold_q      <= '0;
         fail_q      <= '0;
         bad_q       <= '0;
         load_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         consec_q    <= consec_d;
         ref_valid_q <= ref_valid_d;
         ref_min_q   <= ref_min_d;
         ref_hour_q  <= ref_hour_d;
         ref_date_q  <= ref_date_d;
         tmo_q       <= tmo_d;
         hold_q      <= hold_d;
         fail_q      <= fail_d;
         bad_q       <= bad_d;
         load_q      <= load_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      consec_d    = consec_q;
      ref_valid_d = ref_valid_q;
      ref_min_d   = ref_min_q;
      ref_hour_d  = ref_hour_q;
      ref_date_d  = ref_date_q;
      tmo_d       = tmo_q;
      hold_d      = hold_q;
      fail_d      = fail_q;
      bad_d       = bad_q;
      load_d      = 1'b0;
      timeout     = 1'b0;
      consec_new  = consec_q;

      if (!enable) begin
         state_d     = StIdle;
         consec_d    = '0;
         ref_valid_d = 1'b0;
         tmo_d       = '0;
         hold_d      = '0;
      end else if (state_q == StIdle) begin
         state_d = StAcquire;
      end else begin
         // A strobe in the same cycle as a tick keeps the timeout from firing.
         if (frame_strobe) begin
            tmo_d = '0;
         end else if (clk_en) begin
            if (tmo_q == TmoLast) begin
               tmo_d   = '0;
               timeout = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         if (state_q == StHoldover && clk_en) begin
            if (hold_q == HoldLast) begin
               state_d = StAcquire;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         if (timeout) begin
            fail_d      = FailTimeout;
            ref_valid_d = 1'b0;
            consec_d    = '0;
            if (state_q == StLocked) begin
               state_d = StHoldover;
               hold_d  = '0;
            end
         end

         if (frame_strobe) begin
            if (chk != FailNone) begin
               fail_d      = chk;
               bad_d       = bad_inc;
               ref_valid_d = 1'b0;
               consec_d    = '0;
               if (state_q == StLocked) begin
                  state_d = StHoldover;
                  hold_d  = '0;
               end
            end else begin
               // Good frame, consistent or not, becomes the new reference.
               ref_valid_d = 1'b1;
               ref_min_d   = new_min;
               ref_hour_d  = frame_data[HourMsb:HourLsb];
               ref_date_d  = frame_data[YearMsb:DayLsb];
               consec_new  = (ref_valid_q && consistent) ? consec_inc : 3'd1;
               consec_d    = consec_new;
               if (incons) begin
                  fail_d = FailIncons;
                  bad_d  = bad_inc;
               end
               if (state_q == StLocked) begin
                  if (incons) begin
                     state_d = StHoldover;
                     hold_d  = '0;
                  end else begin
                     load_d = 1'b1;
                  end
               end else if (consec_new >= ConfirmCnt) begin
                  state_d = StLocked;
                  load_d  = 1'b1;
               end
            end
         end
      end
   end

   // Outputs
   always_comb begin
      load          = load_q;
      locked        = (state_q == StLocked);
      holdover      = (state_q == StHoldover);
      fail_code     = fail_q;
      bad_frame_cnt = bad_q;
   end

endmodule
